// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: state set, opcodes,
// datapath control bit positions and ALU operation codes.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_BR3,
    S_BR4,
    S_BR5,
    S_BR6,
    S_JR3,
    S_HALT
  } state_t;

  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int unsigned EN_ZIN   = 18;
  localparam int unsigned EN_YIN   = 19;
  localparam int unsigned EN_PCIN  = 20;
  localparam int unsigned EN_MDRIN = 21;
  localparam int unsigned EN_IRIN  = 24;
  localparam int unsigned EN_MARIN = 25;
  localparam int unsigned EN_CONIN = 27;

  localparam int unsigned BS_ZLOWOUT = 19;
  localparam int unsigned BS_PCOUT   = 20;
  localparam int unsigned BS_MDROUT  = 21;
  localparam int unsigned BS_COUT    = 23;

  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_INCPC = 5'd14;

  // First execute state after fetch; unsupported opcodes behave as nop.
  function automatic state_t exec_entry(input logic [4:0] opcode);
    state_t s;
    case (opcode)
      OP_BR:   s = S_BR3;
      OP_JR:   s = S_JR3;
      OP_HALT: s = S_HALT;
      default: s = S_T0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational state-to-control decoder. Outputs depend only on state, except
// the BR6 PC load, which follows the branch condition flip-flop.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0] ADD_OP   = 5'd1,
  parameter logic [4:0] INCPC_OP = 5'd14
) (
  input  state_t      state,
  input  logic        CONFFOut,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic [4:0]  Control_Signals,
  output logic        MD_Read,
  output logic        ReadRAM,
  output logic        WriteRAM,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        halted
);

  always_comb begin
    enable          = '0;
    busSelect       = '0;
    Control_Signals = '0;
    MD_Read         = 1'b0;
    ReadRAM         = 1'b0;
    WriteRAM        = 1'b0;
    Gra             = 1'b0;
    Grb             = 1'b0;
    Grc             = 1'b0;
    Rin             = 1'b0;
    Rout            = 1'b0;
    BAout           = 1'b0;
    halted          = 1'b0;
    case (state)
      S_T0: begin
        busSelect[BS_PCOUT] = 1'b1;
        enable[EN_MARIN]    = 1'b1;
        enable[EN_ZIN]      = 1'b1;
        Control_Signals     = INCPC_OP;
      end
      S_T1: begin
        busSelect[BS_ZLOWOUT] = 1'b1;
        enable[EN_PCIN]       = 1'b1;
        enable[EN_MDRIN]      = 1'b1;
        MD_Read               = 1'b1;
        ReadRAM               = 1'b1;
      end
      S_T2: begin
        busSelect[BS_MDROUT] = 1'b1;
        enable[EN_IRIN]      = 1'b1;
      end
      S_BR3: begin
        Gra              = 1'b1;
        Rout             = 1'b1;
        enable[EN_CONIN] = 1'b1;
      end
      S_BR4: begin
        busSelect[BS_PCOUT] = 1'b1;
        enable[EN_YIN]      = 1'b1;
      end
      S_BR5: begin
        busSelect[BS_COUT] = 1'b1;
        Control_Signals    = ADD_OP;
        enable[EN_ZIN]     = 1'b1;
      end
      S_BR6: begin
        busSelect[BS_ZLOWOUT] = 1'b1;
        enable[EN_PCIN]       = CONFFOut;
      end
      S_JR3: begin
        Gra             = 1'b1;
        Rout            = 1'b1;
        enable[EN_PCIN] = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2) then per-opcode execute steps.
// Holds the state register and next-state logic; outputs come from ctrl_decode.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0] ADD_OP   = 5'd1,
  parameter logic [4:0] INCPC_OP = 5'd14
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        CONFFOut,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic [4:0]  Control_Signals,
  output logic        MD_Read,
  output logic        ReadRAM,
  output logic        WriteRAM,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        halted
);

  state_t     r_state;
  logic [4:0] w_opcode;

  assign w_opcode = ir[31:27];

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_RESET;
    end else begin
      case (r_state)
        S_RESET: r_state <= S_T0;
        S_T0:    r_state <= S_T1;
        S_T1:    r_state <= S_T2;
        S_T2:    r_state <= exec_entry(w_opcode);
        S_BR3:   r_state <= S_BR4;
        S_BR4:   r_state <= S_BR5;
        S_BR5:   r_state <= S_BR6;
        S_BR6:   r_state <= S_T0;
        S_JR3:   r_state <= S_T0;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_RESET;
      endcase
    end
  end

  ctrl_decode #(
    .ADD_OP   (ADD_OP),
    .INCPC_OP (INCPC_OP)
  ) u_decode (
    .state           (r_state),
    .CONFFOut        (CONFFOut),
    .enable          (enable),
    .busSelect       (busSelect),
    .Control_Signals (Control_Signals),
    .MD_Read         (MD_Read),
    .ReadRAM         (ReadRAM),
    .WriteRAM        (WriteRAM),
    .Gra             (Gra),
    .Grb             (Grb),
    .Grc             (Grc),
    .Rin             (Rin),
    .Rout            (Rout),
    .BAout           (BAout),
    .halted          (halted)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: the stimulus process advances an instruction-step model and
// queues the expected control word for each cycle; a monitor compares at negedge.
module tb_control_sequencer;

  typedef enum int {ST_RESET, ST_T0, ST_T1, ST_T2, ST_BR3, ST_BR4, ST_BR5,
                    ST_BR6, ST_JR3, ST_HALT} step_t;

  typedef struct packed {
    logic [31:0] en;
    logic [31:0] bs;
    logic [4:0]  cs;
    logic [8:0]  str;  // {MD_Read,ReadRAM,WriteRAM,Gra,Grb,Grc,Rin,Rout,BAout}
    logic        hlt;
  } ctl_t;

  typedef struct {
    ctl_t  exp;
    step_t step;
    int    cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] ir = '0;
  logic        CONFFOut = 1'b0;
  logic [31:0] enable, busSelect;
  logic [4:0]  Control_Signals;
  logic        MD_Read, ReadRAM, WriteRAM, Gra, Grb, Grc, Rin, Rout, BAout, halted;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  sb_t   sbq[$];
  step_t m_cur = ST_RESET;
  bit    m_valid = 0;
  step_t m_pend[$];

  always #5 clk = ~clk;

  control_sequencer #(
    .ADD_OP   (5'd1),
    .INCPC_OP (5'd14)
  ) dut (
    .clk             (clk),
    .clr             (clr),
    .ir              (ir),
    .CONFFOut        (CONFFOut),
    .enable          (enable),
    .busSelect       (busSelect),
    .Control_Signals (Control_Signals),
    .MD_Read         (MD_Read),
    .ReadRAM         (ReadRAM),
    .WriteRAM        (WriteRAM),
    .Gra             (Gra),
    .Grb             (Grb),
    .Grc             (Grc),
    .Rin             (Rin),
    .Rout            (Rout),
    .BAout           (BAout),
    .halted          (halted)
  );

  // Control word for each step, taken straight from the step table.
  function automatic ctl_t expect_of(step_t s, logic f);
    ctl_t e;
    e = '0;
    case (s)
      ST_T0:  begin e.en = 32'h0204_0000; e.bs = 32'h0010_0000; e.cs = 5'd14; end
      ST_T1:  begin e.en = 32'h0030_0000; e.bs = 32'h0008_0000; e.str = 9'b110000000; end
      ST_T2:  begin e.en = 32'h0100_0000; e.bs = 32'h0020_0000; end
      ST_BR3: begin e.en = 32'h0800_0000; e.str = 9'b000100010; end
      ST_BR4: begin e.en = 32'h0008_0000; e.bs = 32'h0010_0000; end
      ST_BR5: begin e.en = 32'h0004_0000; e.bs = 32'h0080_0000; e.cs = 5'd1; end
      ST_BR6: begin e.en = f ? 32'h0010_0000 : 32'h0; e.bs = 32'h0008_0000; end
      ST_JR3: begin e.en = 32'h0010_0000; e.str = 9'b000100010; end
      ST_HALT: e.hlt = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Model: each instruction is fetch followed by its list of execute steps.
  task automatic model_edge(input logic c, input logic [31:0] i);
    logic [4:0] op;
    op = i[31:27];
    if (c) begin
      m_cur = ST_RESET;
      m_pend.delete();
    end else if (m_cur == ST_HALT) begin
      m_cur = ST_HALT;
    end else if (m_pend.size() > 0) begin
      m_cur = m_pend.pop_front();
    end else if (m_cur == ST_T2 && op == 5'b10011) begin
      m_cur = ST_BR3;
      m_pend = '{ST_BR4, ST_BR5, ST_BR6};
    end else if (m_cur == ST_T2 && op == 5'b10100) begin
      m_cur = ST_JR3;
    end else if (m_cur == ST_T2 && op == 5'b11011) begin
      m_cur = ST_HALT;
    end else begin
      m_cur = ST_T0;
      m_pend = '{ST_T1, ST_T2};
    end
    m_valid = 1;
  endtask

  task automatic step(input logic c, input logic [31:0] i, input logic f);
    sb_t e;
    clr = c;
    ir = i;
    CONFFOut = f;
    if (m_valid) begin
      e.exp = expect_of(m_cur, f);
      e.step = m_cur;
      e.cyc = cyc;
      sbq.push_back(e);
    end
    @(posedge clk);
    cyc++;
    model_edge(c, i);
    #1;
  endtask

  task automatic run(input int n, input logic c, input logic [31:0] i, input logic f);
    for (int k = 0; k < n; k++) step(c, i, f);
  endtask

  initial begin : monitor
    sb_t  e;
    ctl_t act;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        act = {enable, busSelect, Control_Signals,
               {MD_Read, ReadRAM, WriteRAM, Gra, Grb, Grc, Rin, Rout, BAout}, halted};
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL ctl cyc=%0d step=%0d actual en=%h bs=%h cs=%0d str=%b hlt=%b required en=%h bs=%h cs=%0d str=%b hlt=%b",
                   e.cyc, e.step, act.en, act.bs, act.cs, act.str, act.hlt,
                   e.exp.en, e.exp.bs, e.exp.cs, e.exp.str, e.exp.hlt);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] r;
    logic [4:0]  ops[5];
    int          guard;
    ops = '{5'b10011, 5'b10100, 5'b11010, 5'b11011, 5'b00000};

    run(3, 1'b1, 32'h0, 1'b0);
    run(8, 1'b0, 32'h9B00_0019, 1'b1);   // brzr taken
    run(7, 1'b0, 32'h9B08_0019, 1'b0);   // branch not taken
    run(4, 1'b0, 32'hA080_0000, 1'b1);   // jr
    run(3, 1'b0, 32'hD000_0000, 1'b0);   // nop
    run(14, 1'b0, 32'hD800_0000, 1'b0);  // halt, held
    run(2, 1'b1, 32'hD800_0000, 1'b0);
    run(6, 1'b0, 32'hF800_0000, 1'b1);   // unknown opcode as nop

    guard = 0;
    while (m_cur != ST_BR4 && guard < 20) begin
      step(1'b0, 32'h9B00_0019, 1'b1);
      guard++;
    end
    run(1, 1'b1, 32'h9B00_0019, 1'b1);   // abort in BR4
    run(6, 1'b0, 32'hA080_0000, 1'b0);

    for (int k = 0; k < 500; k++) begin
      r = $urandom;
      r[31:27] = (($urandom % 4) == 0) ? r[31:27] : ops[$urandom % 4];
      if (r[31:27] == 5'b11011 && ($urandom % 3) != 0) r[31:27] = 5'b11010;
      step((m_cur == ST_HALT) ? (($urandom % 5) == 0) : (($urandom % 50) == 0),
           r, 1'($urandom));
    end

    step(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the Phase 2 datapath. It is a Moore state machine that walks the fetch cycle (T0–T2) and the execute steps of each supported instruction. It drives the same enable, bus-select, ALU and register-select controls the datapath exposes, so the datapath no longer needs a bench to sequence those controls. It sits beside `datapath` and reads back `ir` and `CONFFOut`.

## Interface
Parameters:
- `ADD_OP`, 5'd1: ALU code for add.
- `INCPC_OP`, 5'd14: ALU code for PC+1.

Ports:
- `clk`, in, 1: system clock; all state changes on its rising edge.
- `clr`, in, 1: reset, synchronous, active-high.
- `ir`, in, 32: instruction register contents; opcode is `ir[31:27]`.
- `CONFFOut`, in, 1: branch condition flip-flop output.
- `enable`, out, 32: register load enables.
  - [18] Zin, [19] Yin, [20] PCin, [21] MDRin, [24] IRin, [25] MARin, [27] CONin.
  - All other bits are 0.
- `busSelect`, out, 32: bus source selects.
  - [19] Zlowout, [20] PCout, [21] MDRout, [23] Cout.
  - All other bits are 0.
- `Control_Signals`, out, 5: ALU operation.
- `MD_Read`, `ReadRAM`, `WriteRAM`, `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`: out, 1 each; datapath strobes.
- `halted`, out, 1: high while in HALT.

## Operation
States: RESET, T0, T1, T2, BR3, BR4, BR5, BR6, JR3, HALT.

Outputs are decoded from the current state only. Any output not listed for a state is 0.
- RESET: all outputs 0.
- T0: busSelect[20], enable[25], enable[18], Control_Signals=INCPC_OP.
- T1: busSelect[19], enable[20], enable[21], MD_Read, ReadRAM.
- T2: busSelect[21], enable[24].
- BR3: Gra, Rout, enable[27].
- BR4: busSelect[20], enable[19].
- BR5: busSelect[23], Control_Signals=ADD_OP, enable[18].
- BR6: busSelect[19]; enable[20] equals `CONFFOut` (combinational pass-through).
- JR3: Gra, Rout, enable[20].
- HALT: `halted`=1; all other outputs 0.

Transitions:
- clr=1 at a rising edge → RESET, from any state.
- RESET → T0 → T1 → T2.
- T2 → decode on `ir[31:27]`:
  - 5'b10011 (br): → BR3.
  - 5'b10100 (jr): → JR3.
  - 5'b11011 (halt): → HALT.
  - 5'b11010 (nop) or any other opcode: → T0.
- BR3 → BR4 → BR5 → BR6 → T0.
- JR3 → T0.
- HALT → HALT; only clr exits.

The branch condition (zr/nz/pl/mi in `ir[20:19]`) is evaluated in the datapath CON logic. This block never decodes the condition.

## Timing
- One state per clock; every state lasts exactly 1 cycle.
- Latencies:
  - Fetch: 3 cycles.
  - br: 7 cycles total.
  - jr: 4 cycles.
  - nop: 3 cycles.
- Outputs are valid within the cycle after the state-register edge and are glitch-free relative to state, except BR6 enable[20], which follows `CONFFOut`.
- `ir` is sampled at the T2→next edge. IR loads at the end of T2, so the decode uses the value present during T2's last edge, which is the datapath's combinationally updated IR. If the datapath IR is registered, the decode must use the registered `ir` at that edge.
- `CONFFOut` must be stable during BR6; CON is loaded at the end of BR3.
- Reset:
  - clr held for N cycles → state stays RESET and all outputs stay 0.
  - The first T0 occurs the cycle after clr is sampled low.
  - clr mid-instruction aborts it with no partial strobes in the following cycle.
- clr together with any transition: clr wins.

## Structure
- Package `cpu_ctrl_pkg`:
  - State enum.
  - Opcode constants OP_BR, OP_JR, OP_NOP, OP_HALT.
  - Named bit indices for `enable` and `busSelect` (e.g. EN_PCIN=20, BS_PCOUT=20).
  - ALU code constants.
- One sub-module, `ctrl_decode`: combinational state→output decoder.
- The top module holds only the state register and the next-state logic.

## Test plan
- Reset: clr=1 for 3 cycles → all outputs 0, `halted`=0. After clr drops, the next cycle is T0 with enable=32'h0204_0000, busSelect=32'h0010_0000, Control_Signals=14.
- Branch taken: ir=32'h9B000019 (brzr R6,25), CONFFOut=1 in BR6 → BR5 has busSelect[23]=1 and Control_Signals=1; BR6 has enable[20]=1; next state is T0.
- Branch not taken: ir=32'h9B080019, CONFFOut=0 → BR6 has enable[20]=0 and busSelect[19]=1; T0 follows 7 cycles after the previous T0.
- jr: ir=32'hA0800000 → JR3 has Gra=Rout=enable[20]=1; T0 follows 4 cycles after the previous T0.
- halt then unknown opcode:
  - ir=32'hD8000000 → `halted`=1 and held for 10 cycles with all other outputs 0; clr returns to RESET.
  - ir=32'hF8000000 → treated as nop, T0 three cycles after the previous T0.
- Abort: clr asserted while in BR4 → next cycle RESET with all outputs 0; then a normal fetch restarts.
